// File: rtl/result_capture_pkg.sv
// Register map, CTRL/STATUS bit positions and sizing helper shared by the result capture hub.
package result_capture_pkg;
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_CH_SEL  = 3'd2;
    localparam logic [2:0] ADDR_LEVEL   = 3'd3;
    localparam logic [2:0] ADDR_DATA_LO = 3'd4;
    localparam logic [2:0] ADDR_DATA_HI = 3'd5;
    localparam logic [2:0] ADDR_LIMIT   = 3'd6;
    localparam logic [2:0] ADDR_COUNT   = 3'd7;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STAT_FINISHED  = 0;
    localparam int STAT_OVF_LSB   = 8;
    localparam int STAT_EMPTY_LSB = 16;

    function automatic int log2_depth(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/result_capture_hub_fifo.sv
// Synchronous FIFO with occupancy count and sync clear; zero-latency show-ahead read data.
// Push while full and pop while empty are ignored; fullness is judged from the registered level.
module sync_fifo_lvl
    import result_capture_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [log2_depth(DEPTH):0]   level
);
    localparam int AW = log2_depth(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is not reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/result_capture_hub.sv
// Captures N_CH result streams into per-channel FIFOs under a sample quota; Avalon-MM slave, read latency 1.
// No backpressure upstream: samples arriving while a FIFO is full are dropped and flagged as overflow.
module result_capture_hub
    import result_capture_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_CH*DATA_W-1:0]   result_data,
    input  logic [N_CH-1:0]          result_valid,
    input  logic [2:0]               avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic [31:0]              avs_readdata,
    output logic                     capture_active,
    output logic                     finished,
    output logic                     irq
);
    localparam int LW = log2_depth(DEPTH) + 1;

    logic              run;
    logic              irq_en;
    logic [2:0]        ch_sel;
    logic [31:0]       limit;
    logic [31:0]       hi_shadow;
    logic [N_CH-1:0]   overflow;
    logic [31:0]       count [N_CH];

    logic [N_CH-1:0]        fifo_full;
    logic [N_CH-1:0]        fifo_empty;
    logic [N_CH*LW-1:0]     lvl_flat;
    logic [N_CH*DATA_W-1:0] dout_flat;
    logic [N_CH-1:0]        quota_ok;
    logic [N_CH-1:0]        accept;
    logic [N_CH-1:0]        ovf_set;
    logic [N_CH-1:0]        pop_ch;
    logic                   all_done;

    logic              wr_ctrl;
    logic              wr_status;
    logic              clear;
    logic              pop_rd;
    logic [LW-1:0]     sel_level;
    logic              sel_empty;
    logic [DATA_W-1:0] sel_dout;
    logic [63:0]       sel_dout_ext;
    logic [31:0]       sel_count;
    logic [31:0]       rd_mux;

    assign wr_ctrl        = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status      = avs_write && (avs_address == ADDR_STATUS);
    assign clear          = wr_ctrl && avs_writedata[CTRL_CLEAR];
    assign pop_rd         = avs_read && (avs_address == ADDR_DATA_LO);
    assign capture_active = enable && run && !finished;
    assign irq            = finished && irq_en;
    assign sel_dout_ext   = 64'(sel_dout);

    always_comb begin
        all_done = (limit != 32'd0);
        quota_ok = '0;
        for (int k = 0; k < N_CH; k++) begin
            quota_ok[k] = (limit == 32'd0) || (count[k] < limit);
            if (count[k] < limit) all_done = 1'b0;
        end
    end

    assign accept  = {N_CH{capture_active && !clear}} & result_valid & ~fifo_full & quota_ok;
    assign ovf_set = {N_CH{capture_active && !clear}} & result_valid &  fifo_full & quota_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign pop_ch[k] = pop_rd && (ch_sel == 3'(k));

        sync_fifo_lvl #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .push  (accept[k]),
            .pop   (pop_ch[k]),
            .din   (result_data[k*DATA_W +: DATA_W]),
            .dout  (dout_flat[k*DATA_W +: DATA_W]),
            .full  (fifo_full[k]),
            .empty (fifo_empty[k]),
            .level (lvl_flat[k*LW +: LW])
        );
    end

    always_comb begin
        sel_level = '0;
        sel_empty = 1'b1;
        sel_dout  = '0;
        sel_count = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_sel == 3'(k)) begin
                sel_level = lvl_flat[k*LW +: LW];
                sel_empty = fifo_empty[k];
                sel_dout  = dout_flat[k*DATA_W +: DATA_W];
                sel_count = count[k];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_RUN]    = run;
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_FINISHED]               = finished;
                rd_mux[STAT_OVF_LSB   +: N_CH]      = overflow;
                rd_mux[STAT_EMPTY_LSB +: N_CH]      = fifo_empty;
            end
            ADDR_CH_SEL:  rd_mux = 32'(ch_sel);
            ADDR_LEVEL:   rd_mux = 32'(sel_level);
            ADDR_DATA_LO: rd_mux = sel_empty ? 32'd0 : sel_dout_ext[31:0];
            ADDR_DATA_HI: rd_mux = hi_shadow;
            ADDR_LIMIT:   rd_mux = limit;
            ADDR_COUNT:   rd_mux = sel_count;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) count[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (clear)
                    count[k] <= '0;
                else if (accept[k] && (count[k] != 32'hFFFF_FFFF))
                    count[k] <= count[k] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= '0;
            run          <= 1'b0;
            irq_en       <= 1'b0;
            ch_sel       <= '0;
            limit        <= '0;
            hi_shadow    <= '0;
            overflow     <= '0;
            finished     <= 1'b0;
        end else begin
            if (avs_read) avs_readdata <= rd_mux;
            // A CLEAR write leaves RUN/IRQ_EN untouched so software can clear without re-arming.
            if (wr_ctrl && !avs_writedata[CTRL_CLEAR]) begin
                run    <= avs_writedata[CTRL_RUN];
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            end
            if (avs_write && (avs_address == ADDR_CH_SEL) && (avs_writedata < 32'(N_CH)))
                ch_sel <= avs_writedata[2:0];
            if (avs_write && (avs_address == ADDR_LIMIT))
                limit <= avs_writedata;

            if (clear) begin
                finished  <= 1'b0;
                overflow  <= '0;
                hi_shadow <= '0;
            end else begin
                if (pop_rd)
                    hi_shadow <= sel_empty ? 32'd0 : sel_dout_ext[63:32];
                if (all_done && !finished)
                    finished <= 1'b1;
                else if (wr_status && avs_writedata[STAT_FINISHED])
                    finished <= 1'b0;
                overflow <= (overflow & ~(wr_status ? avs_writedata[STAT_OVF_LSB +: N_CH] : '0))
                          | ovf_set;
            end
        end
    end
endmodule

// File: tb/tb_result_capture_hub.sv
// Directed and randomized bench for result_capture_hub against a queue-based reference model.
module tb_result_capture_hub;
    localparam int N_CH   = 2;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [N_CH*DATA_W-1:0] result_data;
    logic [N_CH-1:0]        result_valid;
    logic [2:0]             avs_address;
    logic                   avs_read;
    logic                   avs_write;
    logic [31:0]            avs_writedata;
    logic [31:0]            avs_readdata;
    logic                   capture_active;
    logic                   finished;
    logic                   irq;

    result_capture_hub #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .result_data    (result_data),
        .result_valid   (result_valid),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .capture_active (capture_active),
        .finished       (finished),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] mq [N_CH][$];
    logic [31:0] m_cnt [N_CH];
    logic [N_CH-1:0] m_ovf;
    logic        m_fin, m_run, m_irq_en;
    logic [2:0]  m_sel;
    logic [31:0] m_limit, m_shadow;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            mq[k].delete();
            m_cnt[k] = 0;
        end
        m_ovf = '0; m_fin = 0; m_run = 0; m_irq_en = 0;
        m_sel = 0; m_limit = 0; m_shadow = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r = {30'd0, m_irq_en, m_run};
            3'd1: begin
                r[0] = m_fin;
                for (int k = 0; k < N_CH; k++) begin
                    r[8+k]  = m_ovf[k];
                    r[16+k] = (mq[k].size() == 0);
                end
            end
            3'd2: r = 32'(m_sel);
            3'd3: r = 32'(mq[m_sel].size());
            3'd4: r = (mq[m_sel].size() > 0) ? mq[m_sel][0][31:0] : 32'd0;
            3'd5: r = m_shadow;
            3'd6: r = m_limit;
            default: r = m_cnt[m_sel];
        endcase
        return r;
    endfunction

    // One clock cycle of bus/stream activity, with the model advanced by the same rules.
    task automatic step(input logic [N_CH-1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                        input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] rexp;
        logic [63:0] x;
        bit active, clr, done;
        int pre_sz [N_CH];
        result_valid  = v;
        result_data   = {d1, d0};
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = wd;
        rexp   = model_read(a);
        active = enable && m_run && !m_fin;
        clr    = wr && (a == 3'd0) && wd[2];
        done   = (m_limit != 0);
        for (int k = 0; k < N_CH; k++) begin
            pre_sz[k] = mq[k].size();
            if (m_cnt[k] < m_limit) done = 0;
        end
        @(posedge clk);
        if (clr) begin
            for (int k = 0; k < N_CH; k++) begin
                mq[k].delete();
                m_cnt[k] = 0;
            end
            m_ovf = '0; m_fin = 0; m_shadow = 0;
        end else begin
            if (rd && a == 3'd4) begin
                if (pre_sz[m_sel] > 0) begin
                    x = mq[m_sel].pop_front();
                    m_shadow = x[63:32];
                end else begin
                    m_shadow = 0;
                end
            end
            if (wr && a == 3'd1) m_ovf = m_ovf & ~wd[9:8];
            for (int k = 0; k < N_CH; k++) begin
                if (active && v[k] && (m_limit == 0 || m_cnt[k] < m_limit)) begin
                    if (pre_sz[k] < DEPTH) begin
                        mq[k].push_back(k == 0 ? d0 : d1);
                        if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
            end
            if (done && !m_fin) m_fin = 1;
            else if (wr && a == 3'd1 && wd[0]) m_fin = 0;
        end
        if (wr && a == 3'd0 && !wd[2]) begin
            m_run = wd[0]; m_irq_en = wd[1];
        end
        if (wr && a == 3'd2 && wd < N_CH) m_sel = wd[2:0];
        if (wr && a == 3'd6) m_limit = wd;
        @(negedge clk);
        result_valid = '0; avs_read = 0; avs_write = 0;
        if (rd) chk("readdata", avs_readdata, rexp);
        chk("capture_active", {31'd0, capture_active}, {31'd0, enable && m_run && !m_fin});
        chk("finished", {31'd0, finished}, {31'd0, m_fin});
        chk("irq", {31'd0, irq}, {31'd0, m_fin && m_irq_en});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        step('0, 64'd0, 64'd0, 1'b0, 1'b1, a, wd);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        step('0, 64'd0, 64'd0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic push(input logic [N_CH-1:0] v, input logic [63:0] d0, input logic [63:0] d1);
        step(v, d0, d1, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    initial begin
        logic [63:0] base;
        int r;
        reset = 0; enable = 0; result_valid = '0; result_data = '0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        model_reset();
        #1 reset = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_active", {31'd0, capture_active}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 0;
        @(negedge clk);

        // Post-reset register state on every channel
        rd_reg(3'd1);
        chk("status_after_reset", avs_readdata, 32'h0003_0000);
        for (int c = 0; c < N_CH; c++) begin
            wr_reg(3'd2, c);
            rd_reg(3'd3); chk("level_after_reset", avs_readdata, 32'd0);
            rd_reg(3'd7); chk("count_after_reset", avs_readdata, 32'd0);
        end
        wr_reg(3'd2, 0);
        rd_reg(3'd4); chk("pop_empty", avs_readdata, 32'd0);

        // Quota: LIMIT=4, ch0 x4, ch1 x3 then x1
        enable = 1;
        wr_reg(3'd6, 4);
        wr_reg(3'd0, 3);
        base = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 3; i++) push(2'b11, base + i, 64'hA000 + i);
        push(2'b01, base + 3, 64'd0);
        push('0, 64'd0, 64'd0);
        chk("fin_before_quota", {31'd0, finished}, 32'd0);
        push(2'b10, 64'd0, 64'hA003);
        push('0, 64'd0, 64'd0);
        chk("fin_after_quota", {31'd0, finished}, 32'd1);
        chk("irq_after_quota", {31'd0, irq}, 32'd1);
        push(2'b11, 64'hDEAD, 64'hBEEF);
        rd_reg(3'd7); chk("count_capped", avs_readdata, 32'd4);

        // Read-out on ch0
        rd_reg(3'd3); chk("level_before_pop", avs_readdata, 32'd4);
        rd_reg(3'd4); chk("data_lo", avs_readdata, 32'h3333_4444);
        rd_reg(3'd5); chk("data_hi", avs_readdata, 32'h1111_2222);
        rd_reg(3'd3); chk("level_after_pop", avs_readdata, 32'd3);

        // Overflow with LIMIT=0 on ch1
        wr_reg(3'd0, 32'h4);
        wr_reg(3'd6, 0);
        wr_reg(3'd2, 1);
        for (int i = 0; i < 5; i++) push(2'b10, 64'd0, 64'hB000 + i);
        rd_reg(3'd1); chk("ovf_set", avs_readdata & 32'h200, 32'h200);
        rd_reg(3'd3); chk("level_full", avs_readdata, 32'd4);
        rd_reg(3'd7); chk("count_full", avs_readdata, 32'd4);
        wr_reg(3'd1, 32'h200);
        rd_reg(3'd1); chk("ovf_cleared", avs_readdata & 32'h200, 32'h0);

        // Push and pop on a full FIFO in one cycle
        step(2'b10, 64'd0, 64'hC000, 1'b1, 1'b0, 3'd4, 32'd0);
        chk("pop_on_full", avs_readdata, 32'h0000_B000);
        rd_reg(3'd3); chk("level_push_pop_full", avs_readdata, 32'd3);
        rd_reg(3'd1); chk("ovf_push_pop_full", avs_readdata & 32'h200, 32'h200);

        // CLEAR with a sample arriving in the same cycle
        step(2'b11, 64'hE0, 64'hE1, 1'b0, 1'b1, 3'd0, 32'h4);
        rd_reg(3'd3); chk("level_after_clear", avs_readdata, 32'd0);
        rd_reg(3'd7); chk("count_after_clear", avs_readdata, 32'd0);
        rd_reg(3'd0); chk("run_kept", avs_readdata & 32'h1, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 15);
            case (r)
                0: wr_reg(3'd0, ($urandom_range(0, 5) == 0) ? 32'h4 : 32'($urandom_range(0, 3)) | 32'h1);
                1: wr_reg(3'd1, $urandom & 32'h301);
                2: wr_reg(3'd2, $urandom_range(0, 3));
                3: wr_reg(3'd6, $urandom_range(0, 6));
                4, 5, 6, 7, 8:
                    step(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                         1'b1, 1'b0, 3'($urandom_range(0, 7)), 32'd0);
                default: push(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            endcase
        end

        // Asynchronous reset in the middle of a burst
        enable = 1;
        wr_reg(3'd0, 3);
        wr_reg(3'd6, 1);
        push(2'b11, 64'h5, 64'h6);
        push(2'b11, 64'h7, 64'h8);
        rd_reg(3'd6);
        chk("pre_reset_finished", {31'd0, finished}, 32'd1);
        result_valid = 2'b11;
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("reset_readdata", avs_readdata, 32'd0);
        chk("reset_active", {31'd0, capture_active}, 32'd0);
        chk("reset_finished", {31'd0, finished}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        result_valid = '0;
        model_reset();
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        rd_reg(3'd1); chk("status_after_midreset", avs_readdata, 32'h0003_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
